// File: rtl/rr_arbiter_8ch_if.sv
// Request/grant bundle between the requesters (master) and the round-robin arbiter (slave).
interface rr_arbiter_8ch_if;
  logic       enable;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       expired;

  modport master (
    output enable, req,
    input  gnt, gnt_idx, gnt_valid, expired
  );

  modport slave (
    input  enable, req,
    output gnt, gnt_idx, gnt_valid, expired
  );
endinterface

// File: rtl/rr_arbiter_8ch.sv
// 8-requester round-robin arbiter with a rotating priority pointer, one-hot and
// encoded registered grant, a bubble after every grant, and a bounded hold time.
module rr_arbiter_8ch #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic            clk,
  input logic            rst_n,
  rr_arbiter_8ch_if.slave bus
);

  localparam int unsigned N            = 8;
  localparam int unsigned IDX_W        = 3;
  localparam bit          HOLD_LIMITED = (MAX_HOLD != 0);
  localparam int unsigned CNT_W        = HOLD_LIMITED ? $clog2(MAX_HOLD + 1) : 1;
  localparam int unsigned HOLD_LAST    = HOLD_LIMITED ? MAX_HOLD - 1 : 0;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [N-1:0]       gnt_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  logic               gnt_valid_q;
  logic               expired_q;

  logic               win_found_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               drop_c;
  logic               hold_hit_c;
  logic               release_c;

  // Wrap-around search from ptr; scanning farthest-first lets the nearest hit win.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand        = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ptr + IDX_W'(N - 1 - k);
      if (bus.req[cand]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand;
      end
    end
  end

  always_comb begin
    drop_c     = !bus.req[gnt_idx_q];
    hold_hit_c = HOLD_LIMITED && (hold_cnt == CNT_W'(HOLD_LAST));
    release_c  = drop_c || !bus.enable || hold_hit_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable && win_found_c) begin
            state       <= GRANT;
            gnt_q       <= N'(1) << win_idx_c;
            gnt_idx_q   <= win_idx_c;
            gnt_valid_q <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        GRANT: begin
          if (release_c) begin
            state       <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt    <= '0;
            ptr         <= gnt_idx_q + IDX_W'(1);
            // Only a pure timeout is reported; a coincident drop or disable wins.
            expired_q   <= hold_hit_c && !drop_c && bus.enable;
          end else if (HOLD_LIMITED) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_rr_arbiter_8ch.sv
// Bench for rr_arbiter_8ch: two instances (MAX_HOLD=4 and MAX_HOLD=0) share one
// stimulus stream; a reference model feeds a scoreboard queue checked every cycle.
module tb_rr_arbiter_8ch;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       exp;
  } obs_t;

  typedef struct packed {
    obs_t d4;
    obs_t d0;
  } pair_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_8ch_if bus4 ();
  rr_arbiter_8ch_if bus0 ();

  rr_arbiter_8ch #(.MAX_HOLD(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  rr_arbiter_8ch #(.MAX_HOLD(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  int n_cmp = 0;
  int n_bad = 0;
  pair_t sb_q[$];

  // Reference model state, index 0 -> MAX_HOLD=4 instance, 1 -> MAX_HOLD=0 instance
  int mh     [2] = '{4, 0};
  bit m_busy [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_idx  [2];
  bit m_exp  [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0;
      m_ptr[i]  = 0;
      m_cnt[i]  = 0;
      m_idx[i]  = 0;
      m_exp[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic en, input logic [7:0] r);
    bit found;
    int w;
    bit ra, rb, rc;
    m_exp[i] = 1'b0;
    if (!m_busy[i]) begin
      found = 1'b0;
      w     = 0;
      if (en) begin
        for (int k = 0; k < 8; k++) begin
          if (!found && r[(m_ptr[i] + k) % 8]) begin
            found = 1'b1;
            w     = (m_ptr[i] + k) % 8;
          end
        end
      end
      if (found) begin
        m_busy[i] = 1'b1;
        m_idx[i]  = w;
        m_cnt[i]  = 0;
      end
    end else begin
      ra = !r[m_idx[i]];
      rb = !en;
      rc = (mh[i] != 0) && (m_cnt[i] == mh[i] - 1);
      if (ra || rb || rc) begin
        m_busy[i] = 1'b0;
        m_ptr[i]  = (m_idx[i] + 1) % 8;
        m_exp[i]  = rc && !ra && !rb;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.gnt   = m_busy[i] ? 8'(1 << m_idx[i]) : 8'h00;
    o.idx   = 3'(m_idx[i]);
    o.valid = m_busy[i];
    o.exp   = m_exp[i];
    return o;
  endfunction

  function automatic pair_t sample();
    pair_t p;
    p.d4 = '{bus4.gnt, bus4.gnt_idx, bus4.gnt_valid, bus4.expired};
    p.d0 = '{bus0.gnt, bus0.gnt_idx, bus0.gnt_valid, bus0.expired};
    return p;
  endfunction

  // One clock: drive on negedge, predict, then compare just after the rising edge.
  task automatic cycle(input logic en, input logic [7:0] r);
    pair_t e;
    pair_t o;
    @(negedge clk);
    bus4.enable = en; bus4.req = r;
    bus0.enable = en; bus0.req = r;
    model_step(0, en, r);
    model_step(1, en, r);
    e.d4 = model_obs(0);
    e.d0 = model_obs(1);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sample();
    e = sb_q.pop_front();
    check_eq("dut4_out", 32'(o.d4), 32'(e.d4));
    check_eq("dut0_out", 32'(o.d0), 32'(e.d0));
  endtask

  initial begin
    int   starts[$];
    int   n_exp;
    int   n_val;
    logic prev;

    bus4.enable = 1'b0; bus4.req = 8'h00;
    bus0.enable = 1'b0; bus0.req = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dut4", 32'(sample().d4), 32'd0);
    check_eq("rst_dut0", 32'(sample().d0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two requesters, lower one drops: bubble then the other wins
    cycle(1'b1, 8'h81);
    check_eq("t1_gnt0", 32'(bus4.gnt), 32'h01);
    check_eq("t1_idx0", 32'(bus4.gnt_idx), 32'd0);
    cycle(1'b1, 8'h80);
    check_eq("t1_bubble", 32'(bus4.gnt), 32'h00);
    cycle(1'b1, 8'h80);
    check_eq("t1_gnt7", 32'(bus4.gnt), 32'h80);
    check_eq("t1_idx7", 32'(bus4.gnt_idx), 32'd7);
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h00);

    // All requesting, MAX_HOLD=4: 0..7,0 each 4 cycles plus an expiring bubble
    prev = bus4.gnt_valid;
    n_exp = 0;
    n_val = 0;
    for (int c = 0; c < 45; c++) begin
      cycle(1'b1, 8'hFF);
      if (bus4.gnt_valid && !prev) starts.push_back(int'(bus4.gnt_idx));
      if (bus4.expired) n_exp++;
      if (bus4.gnt_valid) n_val++;
      prev = bus4.gnt_valid;
    end
    check_eq("t2_ngrants", 32'(starts.size()), 32'd9);
    for (int k = 0; k < starts.size(); k++) check_eq("t2_order", 32'(starts[k]), 32'(k % 8));
    check_eq("t2_nexpired", 32'(n_exp), 32'd9);
    check_eq("t2_gnt_cycles", 32'(n_val), 32'd36);

    // Lone persistent requester re-granted every 5 cycles
    starts.delete();
    prev = bus4.gnt_valid;
    n_val = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(1'b1, 8'h08);
      if (bus4.gnt_valid && !prev) starts.push_back(int'(bus4.gnt_idx));
      if (bus4.gnt_valid) n_val++;
      prev = bus4.gnt_valid;
    end
    check_eq("t3_ngrants", 32'(starts.size()), 32'd4);
    for (int k = 0; k < starts.size(); k++) check_eq("t3_idx", 32'(starts[k]), 32'd3);
    check_eq("t3_gnt_cycles", 32'(n_val), 32'd16);
    cycle(1'b1, 8'h00);

    // Disable mid-grant; pointer moves past the released index
    cycle(1'b1, 8'h04);
    check_eq("t4_idx2", 32'(bus4.gnt_idx), 32'd2);
    cycle(1'b1, 8'h04);
    cycle(1'b0, 8'h04);
    check_eq("t4_gnt_off", 32'(bus4.gnt), 32'h00);
    check_eq("t4_no_exp", 32'(bus4.expired), 32'd0);
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 8'h04);
      check_eq("t4_idle", 32'(bus4.gnt_valid), 32'd0);
    end
    cycle(1'b1, 8'h0C);
    check_eq("t4_ptr_idx3", 32'(bus4.gnt_idx), 32'd3);
    repeat (3) cycle(1'b1, 8'h0C);
    cycle(1'b0, 8'h0C);
    check_eq("t4_disable_at_limit", 32'(bus4.expired), 32'd0);
    repeat (4) cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h00);
    check_eq("t4_drop_at_limit", 32'(bus4.expired), 32'd0);
    cycle(1'b1, 8'h00);

    // Asynchronous reset between edges while granted
    cycle(1'b1, 8'h30);
    cycle(1'b1, 8'h30);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus4.enable = 1'b0; bus4.req = 8'h00;
    bus0.enable = 1'b0; bus0.req = 8'h00;
    #1;
    check_eq("t5_rst_dut4", 32'(sample().d4), 32'd0);
    check_eq("t5_rst_dut0", 32'(sample().d0), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h30);
    check_eq("t5_first_idx4", 32'(bus4.gnt_idx), 32'd4);
    check_eq("t5_first_idx0", 32'(bus0.gnt_idx), 32'd4);
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h00);

    // Unlimited hold: one continuous grant, never expires
    n_val = 0;
    n_exp = 0;
    for (int c = 0; c < 100; c++) begin
      cycle(1'b1, 8'h20);
      if (bus0.gnt_valid && bus0.gnt_idx == 3'd5) n_val++;
      if (bus0.expired) n_exp++;
    end
    check_eq("t6_hold_cycles", 32'(n_val), 32'd100);
    check_eq("t6_nexpired", 32'(n_exp), 32'd0);
    cycle(1'b1, 8'h00);

    // Random traffic against the model
    for (int c = 0; c < 300; c++) begin
      cycle(($urandom_range(0, 9) != 0), 8'($urandom) & 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
